// File: rtl/u_recv.sv
// u_recv: UART receive engine on the sys_clk domain.
//   Frame = start(0), DATA_W data bits LSB first, stop(1), CELL clocks per bit.
//   Decoded byte is held for the host behind a valid/read handshake; framing
//   errors and overruns are reported as one-cycle pulses.
// Build option: URX_MAJORITY_EN -- every line sample becomes the 2-of-3 majority
//   of rxS at cellCnt MID-1, MID and MID+1, decided at MID+1 (one cycle more latency).
//   Left undefined, a single sample is taken at MID.
module u_recv #(
    parameter int DATA_W = 8,
    parameter int CELL   = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_l,
    input  logic              uart_recH,
    output logic [DATA_W-1:0] rec_dataH,
    output logic              rec_validH,
    input  logic              rec_readH,
    output logic              frame_errH,
    output logic              overrunH
);
    localparam int CW = $clog2(CELL);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] MID  = CW'(CELL / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CELL - 1);
`ifdef URX_MAJORITY_EN
    localparam logic [CW-1:0] DEC  = MID + CW'(1);
`else
    localparam logic [CW-1:0] DEC  = MID;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rxState_t;

    rxState_t          state;
    logic [1:0]        syncQ;
    logic              rxS;
    logic              sampleBit;
    logic [CW-1:0]     cellCnt;
    logic [BW-1:0]     bitCnt;
    logic [DATA_W-1:0] shreg;

    assign rxS = syncQ[1];

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) syncQ <= 2'b11;
        else            syncQ <= {syncQ[0], uart_recH};
    end

`ifdef URX_MAJORITY_EN
    logic [1:0] rxHist;

    // Keep the two previous rxS values so the vote at MID+1 sees MID-1, MID, MID+1.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) rxHist <= 2'b11;
        else            rxHist <= {rxHist[0], rxS};
    end

    assign sampleBit = (rxHist[1] & rxHist[0]) | (rxHist[1] & rxS) | (rxHist[0] & rxS);
`else
    assign sampleBit = rxS;
`endif

    // Frame FSM: bit timing, deserialisation, and the host-facing output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state      <= IDLE;
            cellCnt    <= '0;
            bitCnt     <= '0;
            shreg      <= '0;
            rec_dataH  <= '0;
            rec_validH <= 1'b0;
            frame_errH <= 1'b0;
            overrunH   <= 1'b0;
        end else begin
            frame_errH <= 1'b0;
            overrunH   <= 1'b0;
            // CELL is a power of 2, so the counter wraps to 0 after CELL-1 by itself.
            cellCnt    <= cellCnt + 1'b1;
            // A byte landing in the same cycle overrides this below (new byte wins).
            if (rec_readH) rec_validH <= 1'b0;

            case (state)
                IDLE: begin
                    cellCnt <= '0;
                    if (!rxS) state <= START;
                end
                START: begin
                    if (cellCnt == DEC && sampleBit) begin
                        // Line back high by mid-start: a glitch, not a frame.
                        state   <= IDLE;
                        cellCnt <= '0;
                    end else if (cellCnt == LAST) begin
                        state   <= DATA;
                        cellCnt <= '0;
                        bitCnt  <= '0;
                    end
                end
                DATA: begin
                    if (cellCnt == DEC) shreg <= {sampleBit, shreg[DATA_W-1:1]};
                    if (cellCnt == LAST) begin
                        if (bitCnt == BW'(DATA_W - 1)) begin
                            state   <= STOP;
                            cellCnt <= '0;
                        end else begin
                            bitCnt  <= bitCnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a following start edge is caught on time.
                    if (cellCnt == DEC) begin
                        cellCnt <= '0;
                        if (sampleBit) begin
                            rec_dataH  <= shreg;
                            rec_validH <= 1'b1;
                            overrunH   <= rec_validH & ~rec_readH;
                            state      <= IDLE;
                        end else begin
                            frame_errH <= 1'b1;
                            state      <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // A line held low after a bad stop must not look like a new start.
                    cellCnt <= '0;
                    if (rxS) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    cellCnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_u_recv.sv
// tb_u_recv: randomized bench for u_recv. The line waveform is built as a plain
// array of per-cycle levels; a reference decoder reads bytes off that array and
// schedules completion events, and an output model replays events and host reads.
module tb_u_recv;
    localparam int DW    = 8;
    localparam int CELL  = 16;
    localparam int MID   = CELL / 2 - 1;
`ifdef URX_MAJORITY_EN
    localparam int DEC   = MID + 1;
    localparam int LAT_EXP = 156;
    localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
    localparam int DEC   = MID;
    localparam int LAT_EXP = 155;
    localparam logic [7:0] GLITCH_EXP = 8'hFB;
`endif
    // Falling edge to valid: 2 sync + 1 start detect + (DW+1) cells + DEC + 1 register.
    localparam int EV_OFF = 4 + (DW + 1) * CELL + DEC;

    typedef struct {
        int         cyc;
        bit         good;
        logic [7:0] data;
    } ev_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst_l = 1'b0;
    logic          uart_recH = 1'b1;
    logic          rec_readH = 1'b0;
    logic [DW-1:0] rec_dataH;
    logic          rec_validH;
    logic          frame_errH;
    logic          overrunH;

    int   nChecks = 0;
    int   nErrs = 0;
    int   cyc = 0;
    int   forceRdCyc = -10;
    bit   rdEn = 1'b0;
    int   nFerrSeen = 0;
    int   nOvrSeen = 0;

    logic       wave[$];
    ev_t        evQ[$];
    logic       mValid = 1'b0;
    logic [7:0] mData = 8'h00;
    logic       mOvr = 1'b0;
    logic       mFerr = 1'b0;

    u_recv #(.DATA_W(DW), .CELL(CELL)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_l (sys_rst_l),
        .uart_recH (uart_recH),
        .rec_dataH (rec_dataH),
        .rec_validH(rec_validH),
        .rec_readH (rec_readH),
        .frame_errH(frame_errH),
        .overrunH  (overrunH)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference decoder. rxS during cellCnt=k of a cell starting at slot c
    // carries line slot c+1+k (two sync flops, start detected one cycle later).
    function automatic logic lineAt(input int s);
        if (s < wave.size()) return wave[s];
        return 1'b1;
    endfunction

    function automatic logic cellSample(input int c);
`ifdef URX_MAJORITY_EN
        int ones;
        ones = int'(lineAt(c + MID)) + int'(lineAt(c + MID + 1)) + int'(lineAt(c + MID + 2));
        return (ones >= 2);
`else
        return lineAt(c + MID + 1);
`endif
    endfunction

    task automatic buildFrame(input logic [7:0] d, input logic stopV, input int hold,
                              input int gap, input int glitch);
        wave.delete();
        repeat (CELL) wave.push_back(1'b0);
        for (int i = 0; i < DW; i++) repeat (CELL) wave.push_back(d[i]);
        repeat (CELL) wave.push_back(stopV);
        repeat (hold) wave.push_back(1'b0);
        repeat (gap) wave.push_back(1'b1);
        if (glitch >= 0) wave[glitch] = ~wave[glitch];
    endtask

    task automatic buildPulse(input int len);
        wave.delete();
        repeat (len) wave.push_back(1'b0);
        repeat (24) wave.push_back(1'b1);
    endtask

    // Called just after a rising edge; plays wave[] one slot per cycle.
    task automatic driveWave(input int rstSlot, input bit forceRd);
        ev_t        ev;
        logic [7:0] d;
        d = '0;
        if (cellSample(0) == 1'b0) begin
            for (int i = 0; i < DW; i++) d[i] = cellSample((i + 1) * CELL);
            ev.cyc  = cyc + EV_OFF;
            ev.good = cellSample((DW + 1) * CELL);
            ev.data = d;
            evQ.push_back(ev);
            if (forceRd) forceRdCyc = ev.cyc;
        end
        for (int s = 0; s < wave.size(); s++) begin
            uart_recH = wave[s];
            if (rstSlot >= 0 && s == rstSlot) sys_rst_l = 1'b0;
            if (rstSlot >= 0 && s == rstSlot + 5) sys_rst_l = 1'b1;
            if (rstSlot >= 0 && s == rstSlot + 2) begin
                chk("rst_mid_valid", 32'(rec_validH), 32'd0);
                chk("rst_mid_data",  32'(rec_dataH),  32'd0);
                chk("rst_mid_ferr",  32'(frame_errH), 32'd0);
                chk("rst_mid_ovr",   32'(overrunH),   32'd0);
            end
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic doRead();
        forceRdCyc = cyc + 2;
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    // Output model: apply scheduled completions and host reads at each edge.
    initial begin
        ev_t ev;
        forever begin
            @(posedge sys_clk);
            cyc++;
            if (!sys_rst_l) begin
                mValid = 1'b0;
                mData  = 8'h00;
                mOvr   = 1'b0;
                mFerr  = 1'b0;
                evQ.delete();
            end else begin
                mOvr  = 1'b0;
                mFerr = 1'b0;
                if (evQ.size() > 0 && evQ[0].cyc == cyc) begin
                    ev = evQ.pop_front();
                    if (ev.good) begin
                        mOvr   = mValid && !rec_readH;
                        mValid = 1'b1;
                        mData  = ev.data;
                    end else begin
                        mFerr = 1'b1;
                        if (rec_readH) mValid = 1'b0;
                    end
                end else if (rec_readH) begin
                    mValid = 1'b0;
                end
            end
        end
    end

    // Host read strobes: random when enabled, plus directed one-shot reads.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            rec_readH = ((cyc + 1) == forceRdCyc) || (rdEn && ($urandom_range(0, 7) == 0));
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge sys_clk) begin
        if (!sys_rst_l) begin
            chk("valid", 32'(rec_validH), 32'd0);
            chk("data",  32'(rec_dataH),  32'd0);
            chk("ferr",  32'(frame_errH), 32'd0);
            chk("ovr",   32'(overrunH),   32'd0);
        end else begin
            chk("valid", 32'(rec_validH), 32'(mValid));
            chk("data",  32'(rec_dataH),  32'(mData));
            chk("ferr",  32'(frame_errH), 32'(mFerr));
            chk("ovr",   32'(overrunH),   32'(mOvr));
        end
        if (frame_errH) nFerrSeen++;
        if (overrunH)   nOvrSeen++;
    end

    initial begin
        #5_000_000;
        nErrs++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrs);
        $finish;
    end

    initial begin
        int f0, lat, n, fBase, oBase, kind, g;
        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_valid", 32'(rec_validH), 32'd0);
        chk("reset_data",  32'(rec_dataH),  32'd0);
        chk("reset_ferr",  32'(frame_errH), 32'd0);
        chk("reset_ovr",   32'(overrunH),   32'd0);
        sys_rst_l = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;

        // 1: 0xA5, latency from the line's falling edge to valid
        buildFrame(8'hA5, 1'b1, 0, 8, -1);
        f0 = cyc;
        lat = -1;
        fork
            driveWave(-1, 1'b0);
            begin
                n = 0;
                while (!rec_validH && n < 400) begin
                    @(negedge sys_clk);
                    n++;
                end
                lat = cyc - f0;
            end
        join
        chk("t1_latency", 32'(lat), 32'(LAT_EXP));
        chk("t1_data",    32'(rec_dataH),  32'hA5);
        chk("t1_valid",   32'(rec_validH), 32'd1);
        chk("t1_nferr",   32'(nFerrSeen),  32'd0);
        chk("t1_novr",    32'(nOvrSeen),   32'd0);

        // 2: short low pulse is rejected as a glitch
        doRead();
        chk("t2_cleared", 32'(rec_validH), 32'd0);
        buildPulse(3);
        driveWave(-1, 1'b0);
        chk("t2_valid", 32'(rec_validH), 32'd0);
        chk("t2_nferr", 32'(nFerrSeen),  32'd0);
        chk("t2_novr",  32'(nOvrSeen),   32'd0);

        // 3: bad stop then held-low line, followed by a good 0x81
        fBase = nFerrSeen;
        buildFrame(8'h3C, 1'b0, 64, 8, -1);
        driveWave(-1, 1'b0);
        chk("t3_ferr_pulses", 32'(nFerrSeen - fBase), 32'd1);
        chk("t3_valid_kept",  32'(rec_validH), 32'd0);
        buildFrame(8'h81, 1'b1, 0, 8, -1);
        driveWave(-1, 1'b0);
        chk("t3_data",  32'(rec_dataH),  32'h81);
        chk("t3_valid", 32'(rec_validH), 32'd1);
        chk("t3_ferr_after", 32'(nFerrSeen - fBase), 32'd1);

        // 4: back-to-back overrun, then a read colliding with completion
        doRead();
        oBase = nOvrSeen;
        buildFrame(8'h11, 1'b1, 0, 0, -1);
        driveWave(-1, 1'b0);
        buildFrame(8'h22, 1'b1, 0, 4, -1);
        driveWave(-1, 1'b0);
        chk("t4_ovr_pulses", 32'(nOvrSeen - oBase), 32'd1);
        chk("t4_data",       32'(rec_dataH), 32'h22);
        buildFrame(8'h33, 1'b1, 0, 4, -1);
        driveWave(-1, 1'b1);
        chk("t4_rd_ovr",   32'(nOvrSeen - oBase), 32'd1);
        chk("t4_rd_valid", 32'(rec_validH), 32'd1);
        chk("t4_rd_data",  32'(rec_dataH),  32'h33);

        // 5: reset during bit 4 of 0xFF, then 0x5A
        fBase = nFerrSeen;
        oBase = nOvrSeen;
        buildFrame(8'hFF, 1'b1, 0, 4, -1);
        driveWave(5 * CELL + 4, 1'b0);
        chk("t5_valid", 32'(rec_validH), 32'd0);
        buildFrame(8'h5A, 1'b1, 0, 4, -1);
        driveWave(-1, 1'b0);
        chk("t5_data",  32'(rec_dataH),  32'h5A);
        chk("t5_valid2", 32'(rec_validH), 32'd1);
        chk("t5_pulses", 32'((nFerrSeen - fBase) + (nOvrSeen - oBase)), 32'd0);

        // 6: one-cycle low glitch at the mid-point of data bit 2 of 0xFF
        buildFrame(8'hFF, 1'b1, 0, 4, 3 * CELL + MID + 1);
        driveWave(-1, 1'b0);
        chk("t6_data", 32'(rec_dataH), 32'(GLITCH_EXP));

        // Random traffic with random host reads
        rdEn = 1'b1;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                buildPulse($urandom_range(1, 3));
            end else if (kind == 1) begin
                buildFrame(8'($urandom), 1'b0, $urandom_range(0, 40), $urandom_range(2, 10), -1);
            end else begin
                g = -1;
                if ($urandom_range(0, 2) == 0) g = $urandom_range(CELL, (DW + 1) * CELL - 1);
                buildFrame(8'($urandom), 1'b1, 0, $urandom_range(0, 20), g);
            end
            driveWave(-1, 1'b0);
        end
        rdEn = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrs);
        $finish;
    end
endmodule
